// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: classifies retiring instructions into a FWFT trace FIFO and tracks run/halt/watchdog state
module commit_trace_monitor #(
  parameter int DATA_W = 16,
  parameter int REG_W = 4,
  parameter int CNT_W = 32,
  parameter int DEPTH = 16,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic              regwrite,
  input  logic [REG_W-1:0]  wreg,
  input  logic [DATA_W-1:0] wdata,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] maddr,
  input  logic [DATA_W-1:0] mdata,
  input  logic              halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [CNT_W-1:0]  rec_inum,
  output logic [DATA_W-1:0] rec_pc,
  output logic [REG_W-1:0]  rec_reg,
  output logic [DATA_W-1:0] rec_value,
  output logic [DATA_W-1:0] rec_addr,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              done,
  output logic              timeout
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE, TIMEOUT} state_t;
  localparam int PW = $clog2(DEPTH);
  localparam int REC_W = 3 + CNT_W + REG_W + 3 * DATA_W;
  state_t state;
  logic [PW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] rec, head;
  logic [2:0] kind;
  logic [REG_W-1:0] reg_in;
  logic [DATA_W-1:0] value_in, addr_in;
  logic capture, empty, full, pop, push, drop, has_reg;
  always_comb begin
    capture = state == RUN && commit_valid;
    empty = wr_ptr == rd_ptr;
    full = wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]};
    pop = !empty && rec_ready;
    push = capture && (!full || pop);
    drop = capture && full && !pop;
    wr_nxt = wr_ptr + {{PW{1'b0}}, push};
    rd_nxt = rd_ptr + {{PW{1'b0}}, pop};
    kind = regwrite && memread ? 3'd2 : regwrite ? 3'd1 : halt ? 3'd4 : memwrite ? 3'd3 : 3'd0;
    has_reg = kind == 3'd1 || kind == 3'd2;
    reg_in = has_reg ? wreg : '0;
    value_in = has_reg ? wdata : kind == 3'd3 ? mdata : '0;
    addr_in = kind == 3'd2 || kind == 3'd3 ? maddr : '0;
    rec = {kind, inst_count, pc, reg_in, value_in, addr_in};
    head = empty ? '0 : mem[rd_ptr[PW-1:0]];
    rec_valid = !empty;
    {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr} = head;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= rec;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      inst_count <= '0;
      cycle_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (capture && ~&inst_count) inst_count <= inst_count + CNT_W'(1);
      if (state == RUN && ~&cycle_count) cycle_count <= cycle_count + CNT_W'(1);
      if (drop && ~&drop_count) drop_count <= drop_count + CNT_W'(1);
      if (drop) overflow <= 1'b1;
      if (capture && halt) state <= DRAIN;
      else if (state == RUN && cycle_count == CNT_W'(CYCLE_LIMIT - 1)) begin
        state <= TIMEOUT;
        timeout <= 1'b1;
      end else if (state == DRAIN && wr_nxt == rd_nxt) begin
        state <= DONE;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
Synthesizable retirement-trace capture unit for the pipelined 16-bit CPU. It samples one commit event per cycle and classifies it as REG, LOAD, STORE, HALT or OTHER. Each event is stamped with an instruction number and pushed into a parametrised FIFO, which an on-chip logger, UART dumper or bench drains through a valid/ready port. It also owns the cycle and instruction counters, halt detection and the runaway-cycle watchdog.

Parameters:
DATA_W, 16, width of PC, register write data, memory address and memory data
REG_W, 4, register index width
CNT_W, 32, width of instruction and cycle counters
DEPTH, 16, FIFO entries; power of two, >= 2
CYCLE_LIMIT, 100000, cycle count at which the watchdog fires

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
commit_valid  in  1  an instruction retires this cycle
pc  in  DATA_W  PC of the retiring instruction
regwrite  in  1  register file write
wreg  in  REG_W  destination register
wdata  in  DATA_W  register write data
memread  in  1  data memory read
memwrite  in  1  data memory write
maddr  in  DATA_W  data memory address
mdata  in  DATA_W  store data
halt  in  1  retiring instruction is HLT
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_kind  out  3  0 OTHER, 1 REG, 2 LOAD, 3 STORE, 4 HALT
rec_inum  out  CNT_W  instruction number
rec_pc  out  DATA_W  PC
rec_reg  out  REG_W  register index; 0 unless REG/LOAD
rec_value  out  DATA_W  wdata (REG/LOAD) or mdata (STORE); else 0
rec_addr  out  DATA_W  maddr (LOAD/STORE); else 0
inst_count  out  CNT_W  instructions captured
cycle_count  out  CNT_W  cycles spent in RUN
drop_count  out  CNT_W  records lost to a full FIFO
overflow  out  1  sticky: at least one record dropped
done  out  1  halt captured and FIFO drained
timeout  out  1  watchdog fired

Behaviour:
- Reset: rst is sampled on the clk edge. All counters are 0, FIFO is empty, state is RUN, and every flag and rec_* output is 0. Reset mid-drain discards all FIFO contents with no further handshakes.
- States: RUN, DRAIN, DONE, TIMEOUT.
- RUN:
  - cycle_count increments every cycle.
  - Capture occurs on commit_valid.
  - RUN->DRAIN when a captured event has halt=1.
  - RUN->TIMEOUT when cycle_count == CYCLE_LIMIT-1 and no halt is captured that cycle. If both happen in the same cycle, halt wins.
- DRAIN: no captures; counters freeze. DRAIN->DONE on the cycle the FIFO becomes empty.
- DONE and TIMEOUT are terminal until rst. done=1 only in DONE; timeout=1 only in TIMEOUT. In TIMEOUT the FIFO keeps draining.
- Classification priority:
  - regwrite&memread -> LOAD
  - regwrite -> REG
  - halt -> HALT
  - memwrite -> STORE
  - else OTHER
- Instruction numbering: every captured event gets rec_inum = the inst_count value before the increment, then inst_count += 1. The first record has inum 0. Dropped records still consume an inum.
- FIFO: first-word-fall-through; rec_* are registered FIFO head outputs.
  - rec_valid = not empty.
  - Pop on rec_valid&rec_ready.
  - A captured event is visible on rec_* the cycle after capture at the earliest (1-cycle latency).
  - rec_* hold stable while rec_valid&!rec_ready.
- Full FIFO:
  - If full and a pop occurs in the same cycle, the push is accepted.
  - If full and no pop, the record is dropped: drop_count += 1 and overflow set (sticky).
  - A dropped HALT record still causes RUN->DRAIN.
- Empty FIFO with a simultaneous push and no pop: the push is accepted normally; there is no bypass to rec_* in the same cycle.
- Pointers are log2(DEPTH) bits plus a wrap bit; full and empty are derived from pointer equality and the wrap bit.
- Counters saturate at all-ones; they never wrap.

Test Plan:
- Reset, then commit REG (pc=0x0000, wreg=3, wdata=0x1234), rec_ready=1 -> next cycle: rec_valid=1, kind=1, inum=0, reg=3, value=0x1234, addr=0; inst_count=1.
- LOAD (wreg=5, wdata=0xBEEF, maddr=0x0040), then STORE (maddr=0x0042, mdata=0x00AA), then a no-flag commit -> kinds 2, 3, 0 with inums 0, 1, 2. STORE has reg=0, value=0x00AA, addr=0x0042.
- rec_ready=0, 18 consecutive commits with DEPTH=16 -> 16 buffered, drop_count=2, overflow=1. Drained inums are 0..15 in order, and the 19th commit gets inum 18.
- Commit HALT while 3 records are pending, rec_ready=1 -> no captures after the HALT. done rises the cycle the FIFO empties, and the HALT record is last.
- CYCLE_LIMIT=8, no halt -> timeout=1 after 8 RUN cycles; cycle_count=8; later commits are ignored.
- Assert rst mid-drain with 5 records pending -> next cycle: rec_valid=0, all counters 0, state RUN.
